papu_mix_decimator: RTL
=======================

// Module: papu_mix_decimator
// PURPOSE
//  Weighted sum of the five NES APU channel levels on every APU tick; boxcar-decimates by DECIM.
//  Buffers the 16-bit signed results in a small FIFO.
//  Hands one sample per codec request to the audio codec's audio_output input (replaces audio_effects).
//  Single clock domain: audio_clk.
// PARAMETERS
//  DECIM       32  APU ticks averaged per output sample; power of two, 2..256
//  FIFO_DEPTH  4   output sample FIFO entries; power of two, 2..16
//  DC_SHIFT    10  high-pass pole shift (only with PAPU_DC_BLOCK_EN)
// PORTS
//  clk           in   1   audio_clk; all logic on rising edge
//  reset         in   1   asynchronous, active-low (0 = in reset)
//  apu_tick      in   1   one-cycle strobe; channel inputs valid this cycle
//  pulse1        in   4   pulse 1 level 0..15
//  pulse2        in   4   pulse 2 level 0..15
//  triangle      in   4   triangle level 0..15
//  noise         in   4   noise level 0..15
//  dmc           in   7   DMC level 0..127
//  sample_req    in   1   codec request strobe (sample_req[1])
//  audio_output  out  16  signed sample to codec
//  fifo_level    out  5   current FIFO occupancy 0..FIFO_DEPTH
//  status        out  2   sticky {overflow, underrun}
//  clear_status  in   1   synchronous clear of status; set events in the same cycle win
// BEHAVIOUR
//  Reset: audio_output=0, fifo_level=0, status=0, accumulator=0, tick count=0, last sample=0.
//  Mix, combinational per tick:
//   mix = W_PULSE*(pulse1+pulse2) + W_TRI*triangle + W_NOISE*noise + W_DMC*dmc
//   Unsigned 16-bit; maximum 42726, so no overflow.
//  Accumulate: on apu_tick, acc += mix and cnt++.
//   acc width 16+log2(DECIM); cnt wraps at DECIM.
//  Decimate: on the tick where cnt==DECIM-1:
//   avg = (acc+mix) >> log2(DECIM); sample = avg - MIX_MID; this is signed 16-bit.
//   acc <= 0 in the same cycle; sample is pushed to the FIFO the following cycle.
//  No apu_tick: acc and cnt hold.
//  Push into a full FIFO: the new sample is dropped; status[1] set; FIFO contents unchanged.
//  sample_req pop: audio_output updates on the next rising edge (1-cycle latency).
//   Until the next pop, audio_output holds that value.
//  sample_req with empty FIFO: audio_output holds last value; status[0] set.
//  Push and pop in the same cycle:
//   - both occur; level unchanged; FIFO never reports overflow in that cycle.
//   - if the FIFO was empty, the popped value is the old one (underrun); the pushed sample is retained.
//  Pointers wrap modulo FIFO_DEPTH; fifo_level is derived from pointers with an extra wrap bit.
//  Reset asserted mid-operation: everything returns to reset values immediately.
//   The next sample starts a fresh DECIM window after reset is released.
// CONFIGURATION
//  PAPU_DC_BLOCK_EN defined:
//   - applies a one-pole high-pass at the FIFO output: y = x - x_prev + y_prev - (y_prev >>> DC_SHIFT).
//   - the pole operates on each pop; intermediate is 18-bit signed.
//   - result saturates to [-32768, 32767]; x_prev and y_prev reset to 0.
//   - on underrun the filter state does not advance.
//  Undefined: audio_output is the FIFO output directly; DC_SHIFT is ignored.
// STRUCTURE
//  Package papu_pkg:
//   - W_PULSE=376, W_TRI=427, W_NOISE=247, W_DMC=168, MIX_MID=21363
//   - typedef sample_t (signed [15:0])
//   - function mix_levels()
//  Sub-module papu_sample_fifo: synchronous FIFO with push, pop, full, empty and level.
//  Mix, accumulate, decimate and the output register live in the top module.
// TESTING
//  All channels 0, DECIM=32, 32 ticks:
//   - pushed sample = -21363; one sample_req gives audio_output=-21363 one cycle later.
//  All channels at max (15,15,15,15,127) for 32 ticks: sample = +21363.
//  pulse1 alternates 0 and 15 every tick for 32 ticks:
//   - avg = 188*15 = 2820; sample = 2820-21363 = -18543.
//  Six decimated samples, no requests, FIFO_DEPTH=4:
//   - fifo_level=4; status=2'b10; four pops return samples 1..4 in order.
//  sample_req with FIFO empty after reset:
//   - audio_output stays 0; status=2'b01; clear_status then gives status=0.
//  Reset low mid-window (cnt=17), then release and run 32 ticks at constant input:
//   - the first sample equals that constant's mix minus MIX_MID, with no partial-window residue.

Source files
------------

// File: rtl/papu_pkg.sv
// Shared types, mix weights and the channel mix function for the NES APU output mixer.
package papu_pkg;

    localparam logic [15:0] W_PULSE = 16'd376;
    localparam logic [15:0] W_TRI   = 16'd427;
    localparam logic [15:0] W_NOISE = 16'd247;
    localparam logic [15:0] W_DMC   = 16'd168;
    localparam logic [15:0] MIX_MID = 16'd21363;

    typedef logic signed [15:0] sample_t;

    // Peak is 42726, so plain 16-bit unsigned arithmetic never wraps.
    function automatic logic [15:0] mix_levels(
        input logic [3:0] pulse1_lvl,
        input logic [3:0] pulse2_lvl,
        input logic [3:0] triangle_lvl,
        input logic [3:0] noise_lvl,
        input logic [6:0] dmc_lvl
    );
        logic [15:0] pulse_sum;
        pulse_sum = 16'(pulse1_lvl) + 16'(pulse2_lvl);
        return W_PULSE * pulse_sum
             + W_TRI   * 16'(triangle_lvl)
             + W_NOISE * 16'(noise_lvl)
             + W_DMC   * 16'(dmc_lvl);
    endfunction

endpackage

// File: rtl/papu_sample_fifo.sv
// Synchronous sample FIFO; pointers carry an extra wrap bit so full/empty/level fall out directly.
module papu_sample_fifo
    import papu_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  sample_t                  wr_data,
    output sample_t                  rd_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);

    sample_t       mem [DEPTH];
    logic [AW:0]   wr_ptr;
    logic [AW:0]   rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign level   = wr_ptr - rd_ptr;
    assign rd_data = mem[rd_ptr[AW-1:0]];

    // A simultaneous pop frees the slot, so a push into a full FIFO is still accepted.
    assign do_push = push && (!full || pop);
    assign do_pop  = pop && !empty;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= wr_data;
    end

endmodule

// File: rtl/papu_mix_decimator.sv
// APU channel mixer with boxcar decimation, sample FIFO and codec output register.
// Optional one-pole DC-blocking high-pass at the FIFO output: define PAPU_DC_BLOCK_EN.
module papu_mix_decimator
    import papu_pkg::*;
#(
    parameter int DECIM      = 32,
    parameter int FIFO_DEPTH = 4,
    parameter int DC_SHIFT   = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        apu_tick,
    input  logic [3:0]  pulse1,
    input  logic [3:0]  pulse2,
    input  logic [3:0]  triangle,
    input  logic [3:0]  noise,
    input  logic [6:0]  dmc,
    input  logic        sample_req,
    output sample_t     audio_output,
    output logic [4:0]  fifo_level,
    output logic [1:0]  status,
    input  logic        clear_status
);

    localparam int ACC_SH = $clog2(DECIM);
    localparam int ACC_W  = 16 + ACC_SH;
    localparam int LVL_W  = $clog2(FIFO_DEPTH) + 1;

    if ((1 << ACC_SH) != DECIM || DECIM < 2 || DECIM > 256)
        $error("DECIM must be a power of two in 2..256");
    if ((1 << (LVL_W - 1)) != FIFO_DEPTH || FIFO_DEPTH < 2 || FIFO_DEPTH > 16)
        $error("FIFO_DEPTH must be a power of two in 2..16");
    if (DC_SHIFT < 1 || DC_SHIFT > 15)
        $error("DC_SHIFT must be in 1..15");

    logic [15:0]        mix;
    logic [ACC_W-1:0]   acc_sum;
    logic [15:0]        avg;
    logic [ACC_W-1:0]   acc_p0;
    logic [ACC_SH-1:0]  cnt_p0;
    sample_t            sample_p1;
    logic               vld_p1;

    sample_t            rd_data;
    logic               full;
    logic               empty;
    logic [LVL_W-1:0]   level;
    logic               pop_ok;
    logic               overflow;
    logic               underrun;

    assign mix     = mix_levels(pulse1, pulse2, triangle, noise, dmc);
    assign acc_sum = acc_p0 + ACC_W'(mix);
    assign avg     = acc_sum[ACC_W-1:ACC_SH];

    // Stage p0: accumulate one window; p1: centred sample waiting to be pushed
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            acc_p0    <= '0;
            cnt_p0    <= '0;
            sample_p1 <= '0;
            vld_p1    <= 1'b0;
        end else begin
            vld_p1 <= 1'b0;
            if (apu_tick) begin
                if (cnt_p0 == ACC_SH'(DECIM - 1)) begin
                    acc_p0    <= '0;
                    cnt_p0    <= '0;
                    sample_p1 <= sample_t'(avg - MIX_MID);
                    vld_p1    <= 1'b1;
                end else begin
                    acc_p0 <= acc_sum;
                    cnt_p0 <= cnt_p0 + 1'b1;
                end
            end
        end
    end

    papu_sample_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push    (vld_p1),
        .pop     (sample_req),
        .wr_data (sample_p1),
        .rd_data (rd_data),
        .full    (full),
        .empty   (empty),
        .level   (level)
    );

    assign pop_ok   = sample_req && !empty;
    assign overflow = vld_p1 && full && !sample_req;
    assign underrun = sample_req && empty;
    assign fifo_level = 5'(level);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            status <= 2'b00;
        end else begin
            status[1] <= (status[1] && !clear_status) || overflow;
            status[0] <= (status[0] && !clear_status) || underrun;
        end
    end

`ifdef PAPU_DC_BLOCK_EN
    function automatic sample_t sat16(input logic signed [17:0] v);
        if (v > 18'sd32767)       return 16'sh7FFF;
        else if (v < -18'sd32768) return 16'sh8000;
        else                      return sample_t'(v);
    endfunction

    sample_t              x_prev;
    sample_t              y_prev;
    logic signed [17:0]   y_raw;

    assign y_raw = 18'(rd_data) - 18'(x_prev) + 18'(y_prev) - 18'(y_prev >>> DC_SHIFT);

    // Stage p2: filtered output register, advancing only on a successful pop
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            audio_output <= '0;
            x_prev       <= '0;
            y_prev       <= '0;
        end else if (pop_ok) begin
            audio_output <= sat16(y_raw);
            x_prev       <= rd_data;
            y_prev       <= sat16(y_raw);
        end
    end
`else
    // Stage p2: output register, holds across underruns
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) audio_output <= '0;
        else if (pop_ok) audio_output <= rd_data;
    end
`endif

endmodule
